// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for a small ALU: synchronizes the two buttons,
// steps through A/B/opcode entry, validates the opcode and captures the ALU result.
package alu_operand_sequencer_pkg;
    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_MULT   = 4'd2,
        OP_DIV    = 4'd3,
        OP_MOD    = 4'd4,
        OP_AND    = 4'd5,
        OP_OR     = 4'd6,
        OP_XOR    = 4'd7,
        OP_LSHIFT = 4'd8,
        OP_RSHIFT = 4'd9
    } op_code_t;

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4,
        ERROR   = 3'd5
    } state_t;
endpackage

module alu_operand_sequencer
    import alu_operand_sequencer_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] sw,
    input  logic [3:0]   op_sel,
    input  logic         btn_enter,
    input  logic         btn_clear,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output op_code_t     alu_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_z,
    input  logic         alu_n,
    input  logic         alu_v,
    input  logic         alu_c,
    output logic [N-1:0] result,
    output logic [3:0]   flags,
    output logic         result_valid,
    output logic         err,
    output logic [2:0]   state_o,
    output logic [7:0]   op_count
);

    state_t     state, state_next;
    logic [1:0] enter_sync, clear_sync;
    logic       enter_prev, clear_prev;
    logic       enter_pulse, clear_pulse;
    logic       op_ok;
    logic       load_a, load_b, load_op, capture, set_err, clr_valid, clr_err;

    // Two-flop synchronizers plus a delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enter_sync <= 2'b00;
            clear_sync <= 2'b00;
            enter_prev <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            enter_sync <= {enter_sync[0], btn_enter};
            clear_sync <= {clear_sync[0], btn_clear};
            enter_prev <= enter_sync[1];
            clear_prev <= clear_sync[1];
        end
    end

    assign enter_pulse = enter_sync[1] & ~enter_prev;
    assign clear_pulse = clear_sync[1] & ~clear_prev;

    // Division and modulo by zero are refused before they ever reach the ALU.
    assign op_ok = (op_sel <= 4'd9) &&
                   !(((op_sel == 4'd3) || (op_sel == 4'd4)) && (alu_b == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD_A;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        capture    = 1'b0;
        set_err    = 1'b0;
        clr_valid  = 1'b0;
        clr_err    = 1'b0;
        if (clear_pulse) begin
            state_next = LOAD_A;
            clr_valid  = 1'b1;
            clr_err    = 1'b1;
        end else begin
            unique case (state)
                LOAD_A: if (enter_pulse) begin
                    state_next = LOAD_B;
                    load_a     = 1'b1;
                    clr_valid  = 1'b1;
                    clr_err    = 1'b1;
                end
                LOAD_B: if (enter_pulse) begin
                    state_next = LOAD_OP;
                    load_b     = 1'b1;
                end
                LOAD_OP: if (enter_pulse) begin
                    if (op_ok) begin
                        state_next = EXEC;
                        load_op    = 1'b1;
                    end else begin
                        state_next = ERROR;
                        set_err    = 1'b1;
                    end
                end
                EXEC: begin
                    state_next = SHOW;
                    capture    = 1'b1;
                end
                SHOW, ERROR: if (enter_pulse) begin
                    state_next = LOAD_A;
                    clr_err    = 1'b1;
                end
                default: state_next = LOAD_A;
            endcase
        end
    end

    // Datapath registers; operands only change on their own capture strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_op       <= OP_ADD;
            result       <= '0;
            flags        <= 4'b0000;
            result_valid <= 1'b0;
            err          <= 1'b0;
            op_count     <= 8'd0;
        end else begin
            if (load_a)  alu_a  <= sw;
            if (load_b)  alu_b  <= sw;
            if (load_op) alu_op <= op_code_t'(op_sel);
            if (capture) begin
                result       <= alu_out;
                flags        <= {alu_z, alu_n, alu_v, alu_c};
                result_valid <= 1'b1;
                if (op_count != 8'hFF) op_count <= op_count + 8'd1;
            end else if (clr_valid) begin
                result_valid <= 1'b0;
            end
            if (set_err)      err <= 1'b1;
            else if (clr_err) err <= 1'b0;
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench: directed table, press-level reference model with random
// stimulus, saturation, held-button, and reset corner sequences.
module tb_alu_operand_sequencer;
    import alu_operand_sequencer_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] sw = '0;
    logic [3:0]   op_sel = 4'd0;
    logic         btn_enter = 1'b0;
    logic         btn_clear = 1'b0;
    logic [N-1:0] alu_a, alu_b, alu_out, result;
    op_code_t     alu_op;
    logic         alu_z, alu_n, alu_v, alu_c;
    logic [3:0]   flags;
    logic         result_valid, err;
    logic [2:0]   state_o;
    logic [7:0]   op_count;

    int n_checks = 0;
    int n_errors = 0;

    // Press-level reference model state.
    int           m_st, m_cnt;
    logic [N-1:0] m_a, m_b, m_res;
    logic [3:0]   m_op, m_flg;
    logic         m_rv, m_er;

    typedef struct {
        logic [1:0]   act;
        logic [N-1:0] sw;
        logic [3:0]   op;
        int           st;
        logic [N-1:0] a, b;
        logic [3:0]   eop;
        logic [N-1:0] res;
        logic [3:0]   flg;
        logic         rv, er;
        int           cnt;
    } vec_t;

    vec_t vecs[22];

    alu_operand_sequencer #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .op_sel(op_sel),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_out(alu_out), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_c(alu_c),
        .result(result), .flags(flags), .result_valid(result_valid), .err(err),
        .state_o(state_o), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Environment ALU: returns {Z, N, V, C, result}.
    function automatic logic [N+3:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                               input logic [3:0] op);
        logic [N-1:0]   r;
        logic           n_f, v_f, c_f;
        logic [N:0]     s;
        logic [2*N-1:0] p;
        r = '0; n_f = 1'b0; v_f = 1'b0; c_f = 1'b0;
        s = {1'b0, a} + {1'b0, b};
        p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
        case (op)
            4'd0: begin r = s[N-1:0]; c_f = s[N]; end
            4'd1: begin r = a - b; n_f = (a < b); end
            4'd2: begin r = p[N-1:0]; v_f = (p[2*N-1:N] != '0); end
            4'd3: r = (b == '0) ? '0 : a / b;
            4'd4: r = (b == '0) ? '0 : a % b;
            4'd5: r = a & b;
            4'd6: r = a | b;
            4'd7: r = a ^ b;
            4'd8: r = a << b;
            4'd9: r = a >> b;
            default: r = '0;
        endcase
        return {(r == '0), n_f, v_f, c_f, r};
    endfunction

    assign {alu_z, alu_n, alu_v, alu_c, alu_out} = alu_model(alu_a, alu_b, alu_op);

    task automatic check(input string tag, input string what,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s.%s: got %0h, expected %0h", tag, what, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input int st, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [3:0] op,
                               input logic [N-1:0] res, input logic [3:0] flg,
                               input logic rv, input logic er, input int cnt);
        check(tag, "state", 32'(state_o), st);
        check(tag, "alu_a", 32'(alu_a), 32'(a));
        check(tag, "alu_b", 32'(alu_b), 32'(b));
        check(tag, "alu_op", 32'(alu_op), 32'(op));
        check(tag, "result", 32'(result), 32'(res));
        check(tag, "flags", 32'(flags), 32'(flg));
        check(tag, "result_valid", 32'(result_valid), 32'(rv));
        check(tag, "err", 32'(err), 32'(er));
        check(tag, "op_count", 32'(op_count), cnt);
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, m_st, m_a, m_b, m_op, m_res, m_flg, m_rv, m_er, m_cnt);
    endtask

    task automatic modelReset();
        m_st = 0; m_a = '0; m_b = '0; m_op = 4'd0; m_res = '0; m_flg = 4'd0;
        m_rv = 1'b0; m_er = 1'b0; m_cnt = 0;
    endtask

    task automatic modelPress(input logic enter, input logic clear,
                              input logic [N-1:0] swv, input logic [3:0] opv);
        if (clear) begin
            m_st = 0; m_rv = 1'b0; m_er = 1'b0;
        end else if (enter) begin
            case (m_st)
                0: begin m_a = swv; m_rv = 1'b0; m_er = 1'b0; m_st = 1; end
                1: begin m_b = swv; m_st = 2; end
                2: if (opv <= 4'd9 && !((opv == 4'd3 || opv == 4'd4) && m_b == '0)) begin
                       m_op = opv;
                       {m_flg, m_res} = alu_model(m_a, m_b, opv);
                       m_rv = 1'b1;
                       if (m_cnt < 255) m_cnt++;
                       m_st = 4;
                   end else begin
                       m_er = 1'b1; m_st = 5;
                   end
                default: begin m_st = 0; m_er = 1'b0; end
            endcase
        end
    endtask

    // One button press: hold for 'hold' cycles, release, then let the edge detector settle.
    task automatic applyStimulus(input logic enter, input logic clear, input logic [N-1:0] swv,
                                 input logic [3:0] opv, input int hold);
        @(negedge clk);
        sw = swv; op_sel = opv; btn_enter = enter; btn_clear = clear;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic pressAndCheck(input string tag, input logic enter, input logic clear,
                                 input logic [N-1:0] swv, input logic [3:0] opv, input int hold);
        applyStimulus(enter, clear, swv, opv, hold);
        modelPress(enter, clear, swv, opv);
        checkModel(tag);
    endtask

    initial begin
        bit       exec_seen;
        logic [N-1:0] rsw;
        logic [3:0]   rop;

        vecs[0]  = '{2'b01, 4'd3,  4'd0,  1, 4'd3, 4'd0, 4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 0};
        vecs[1]  = '{2'b01, 4'd5,  4'd0,  2, 4'd3, 4'd5, 4'd0, 4'h0, 4'h0, 1'b0, 1'b0, 0};
        vecs[2]  = '{2'b01, 4'd0,  4'd0,  4, 4'd3, 4'd5, 4'd0, 4'h8, 4'h0, 1'b1, 1'b0, 1};
        vecs[3]  = '{2'b01, 4'd0,  4'd0,  0, 4'd3, 4'd5, 4'd0, 4'h8, 4'h0, 1'b1, 1'b0, 1};
        vecs[4]  = '{2'b01, 4'd7,  4'd0,  1, 4'd7, 4'd5, 4'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[5]  = '{2'b01, 4'd0,  4'd0,  2, 4'd7, 4'd0, 4'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[6]  = '{2'b01, 4'd0,  4'd3,  5, 4'd7, 4'd0, 4'd0, 4'h8, 4'h0, 1'b0, 1'b1, 1};
        vecs[7]  = '{2'b01, 4'd0,  4'd0,  0, 4'd7, 4'd0, 4'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[8]  = '{2'b01, 4'd2,  4'd0,  1, 4'd2, 4'd0, 4'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[9]  = '{2'b01, 4'd6,  4'd0,  2, 4'd2, 4'd6, 4'd0, 4'h8, 4'h0, 1'b0, 1'b0, 1};
        vecs[10] = '{2'b01, 4'd0,  4'd1,  4, 4'd2, 4'd6, 4'd1, 4'hC, 4'h4, 1'b1, 1'b0, 2};
        vecs[11] = '{2'b01, 4'd0,  4'd0,  0, 4'd2, 4'd6, 4'd1, 4'hC, 4'h4, 1'b1, 1'b0, 2};
        vecs[12] = '{2'b01, 4'd1,  4'd0,  1, 4'd1, 4'd6, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[13] = '{2'b01, 4'd1,  4'd0,  2, 4'd1, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[14] = '{2'b01, 4'd0,  4'd12, 5, 4'd1, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b1, 2};
        vecs[15] = '{2'b01, 4'd0,  4'd0,  0, 4'd1, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[16] = '{2'b01, 4'd9,  4'd0,  1, 4'd9, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[17] = '{2'b11, 4'd11, 4'd0,  0, 4'd9, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[18] = '{2'b01, 4'd15, 4'd0,  1, 4'hF, 4'd1, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[19] = '{2'b01, 4'd3,  4'd0,  2, 4'hF, 4'd3, 4'd1, 4'hC, 4'h4, 1'b0, 1'b0, 2};
        vecs[20] = '{2'b01, 4'd0,  4'd2,  4, 4'hF, 4'd3, 4'd2, 4'hD, 4'h2, 1'b1, 1'b0, 3};
        vecs[21] = '{2'b10, 4'd0,  4'd0,  0, 4'hF, 4'd3, 4'd2, 4'hD, 4'h2, 1'b0, 1'b0, 3};

        #3 rst_n = 1'b0;
        #1 checkOutput("reset", 0, '0, '0, 4'd0, '0, 4'd0, 1'b0, 1'b0, 0);
        modelReset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i].act[0], vecs[i].act[1], vecs[i].sw, vecs[i].op, 2);
            modelPress(vecs[i].act[0], vecs[i].act[1], vecs[i].sw, vecs[i].op);
            checkOutput($sformatf("vec%0d", i), vecs[i].st, vecs[i].a, vecs[i].b, vecs[i].eop,
                        vecs[i].res, vecs[i].flg, vecs[i].rv, vecs[i].er, vecs[i].cnt);
        end

        for (int i = 0; i < 300; i++) begin
            int unsigned kind;
            kind = $urandom_range(0, 19);
            rsw  = N'($urandom);
            if (m_st == 1 && $urandom_range(0, 3) == 0) rsw = '0;
            rop  = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
            pressAndCheck($sformatf("rand%0d", i), kind != 0, kind <= 1, rsw, rop,
                          int'($urandom_range(1, 4)));
        end

        for (int k = 0; k < 260; k++) begin
            if (m_st != 0) pressAndCheck("sat_clr", 1'b0, 1'b1, '0, 4'd0, 1);
            pressAndCheck("sat_a", 1'b1, 1'b0, N'($urandom), 4'd0, 1);
            pressAndCheck("sat_b", 1'b1, 1'b0, N'($urandom), 4'd0, 1);
            pressAndCheck("sat_op", 1'b1, 1'b0, '0, 4'd0, 1);
        end
        check("saturate", "op_count", 32'(op_count), 32'd255);

        if (m_st != 0) pressAndCheck("hold_clr", 1'b0, 1'b1, '0, 4'd0, 1);
        pressAndCheck("hold50", 1'b1, 1'b0, 4'd6, 4'd0, 50);
        check("hold50", "one_advance", 32'(state_o), 32'd1);

        // Button already held when reset is released.
        @(negedge clk);
        btn_enter = 1'b1; sw = 4'd10;
        rst_n = 1'b0;
        modelReset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        btn_enter = 1'b0;
        repeat (4) @(negedge clk);
        modelPress(1'b1, 1'b0, 4'd10, 4'd0);
        checkModel("held_reset");

        // Reset landing in the single EXEC cycle.
        pressAndCheck("exec_b", 1'b1, 1'b0, 4'd4, 4'd0, 1);
        @(negedge clk);
        op_sel = 4'd0; btn_enter = 1'b1;
        exec_seen = 1'b0;
        for (int c = 0; c < 10 && !exec_seen; c++) begin
            @(negedge clk);
            btn_enter = 1'b0;
            if (state_o == 3'd3) exec_seen = 1'b1;
        end
        check("exec_rst", "exec_seen", 32'(exec_seen), 32'd1);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkModel("exec_rst");
        check("exec_rst", "op_count_zero", 32'(op_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkModel("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_sequencer.md
ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

Interface
REQ-001 The block SHALL take parameter N, default 4, as the operand/result width matching the ALU datapath.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port sw, input, N, the operand entry switches.
REQ-005 The block SHALL have port op_sel, input, 4, the raw opcode entry value.
REQ-006 The block SHALL have port btn_enter, input, 1, an asynchronous level-type advance button.
REQ-007 The block SHALL have port btn_clear, input, 1, an asynchronous level-type abort button.
REQ-008 The block SHALL have ports alu_a and alu_b, output, N each, the registered operands driven to the ALU.
REQ-009 The block SHALL have port alu_op, output, OpCode, the registered opcode driven to the ALU.
REQ-010 The block SHALL have port alu_out, input, N, the ALU result, and alu_z/alu_n/alu_v/alu_c, input, 1 each, the ALU flags.
REQ-011 The block SHALL have port result, output, N, the captured ALU result, and flags, output, 4, the captured {Z,N,V,C}.
REQ-012 The block SHALL have port result_valid, output, 1, high while result/flags hold a valid operation.
REQ-013 The block SHALL have port err, output, 1, high when the last command was rejected.
REQ-014 The block SHALL have port state_o, output, 3, the current FSM state encoding for display.
REQ-015 The block SHALL have port op_count, output, 8, a saturating count of completed operations.

Function
REQ-016 btn_enter and btn_clear SHALL each pass through a two-flop synchronizer followed by a rising-edge detector producing a one-cycle pulse; a held button yields exactly one pulse.
REQ-017 The FSM SHALL have states LOAD_A=0, LOAD_B=1, LOAD_OP=2, EXEC=3, SHOW=4, ERROR=5.
REQ-018 LOAD_A: the enter pulse SHALL register sw into alu_a and move to LOAD_B; result_valid and err SHALL clear on this transition.
REQ-019 LOAD_B: the enter pulse SHALL register sw into alu_b and move to LOAD_OP.
REQ-020 LOAD_OP: on the enter pulse, an op_sel value of 0..9 (Add, Sub, Mult, Div, Mod, And, Or, Xor, LShift, RShift, in that order) SHALL be registered into alu_op, moving to EXEC.
REQ-021 LOAD_OP: on the enter pulse, op_sel greater than 9, or Div/Mod with alu_b equal to 0, SHALL move to ERROR without changing alu_op, result or op_count.
REQ-022 EXEC SHALL last exactly one cycle: at its end, alu_out and the four flags are registered into result/flags, result_valid is set, op_count increments (saturating at 255), and the FSM moves to SHOW.
REQ-023 SHOW and ERROR: the enter pulse SHALL return to LOAD_A; ERROR holds err=1 until that transition.
REQ-024 The clear pulse SHALL move any state to LOAD_A on the next edge, clearing result_valid and err but preserving alu_a, alu_b, alu_op, result, flags and op_count.
REQ-025 Simultaneous enter and clear pulses SHALL be resolved as clear wins.
REQ-026 Enter pulses arriving during EXEC SHALL be ignored.
REQ-027 alu_a, alu_b and alu_op SHALL be stable from entry to EXEC until the next capture in LOAD_A/B/OP.
REQ-028 Latency from btn_enter rising (meeting setup) to the resulting state change SHALL be 3 clk edges.

Reset
REQ-029 Asserting rst_n low SHALL immediately force: state LOAD_A; alu_a, alu_b, result and flags 0; alu_op Add; result_valid, err 0; op_count 0; synchronizer flops 0.
REQ-030 Reset mid-operation, including during EXEC, SHALL discard the operation with no op_count increment.
REQ-031 After rst_n deasserts, a button already held high SHALL produce one pulse.

Verification
REQ-032 Entries sw=3, sw=5, op_sel=0 with the ALU model -> alu_out=8; result=8, flags=0000, result_valid=1, op_count=1, state SHOW.
REQ-033 Entries A=7, B=0, op_sel=3 (Div) -> ERROR, err=1, result unchanged, op_count unchanged; next enter -> LOAD_A, err=0.
REQ-034 op_sel=12 -> ERROR, and alu_op keeps its previous value.
REQ-035 Enter and clear asserted together in LOAD_B -> LOAD_A, alu_b unchanged.
REQ-036 Run 256 operations -> op_count=255; btn_enter held for 50 cycles -> one state advance only.
REQ-037 Assert rst_n low during EXEC -> all outputs take their reset values within the same cycle, and op_count=0.
